// File: rtl/if_id_fetch_stage.sv
// if_id_fetch_stage: PC/fetch FSM with one-entry skid buffer feeding the IF/ID register and decoded fields.
module if_id_fetch_stage #(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ready,
    input  logic [31:0]         imem_rdata,
    input  logic                stall,
    input  logic                flush,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    output logic                if_id_valid,
    output logic [31:0]         if_id_instr,
    output logic [PC_WIDTH-1:0] if_id_pc4,
    output logic [5:0]          opcode,
    output logic [4:0]          rs,
    output logic [4:0]          rt,
    output logic [4:0]          rd,
    output logic [4:0]          shamt,
    output logic [5:0]          funct,
    output logic [15:0]         imm16
);
    localparam logic [1:0] S_WAIT  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HELD  = 2'd2;

    logic [1:0]          r_state, w_state_nx;
    logic [PC_WIDTH-1:0] r_pc, w_pc_nx, w_pc4;
    logic                r_valid, w_valid_nx, w_ld;
    logic [31:0]         r_instr, w_instr_nx;
    logic [PC_WIDTH-1:0] r_pc4, w_pc4_nx;
    logic [31:0]         r_skid_instr;
    logic [PC_WIDTH-1:0] r_skid_pc4;
    logic                w_skid_ld, w_done;

    assign imem_req  = r_state == S_FETCH;
    assign imem_addr = r_pc;
    assign w_done    = imem_req & imem_ready;
    assign w_pc4     = r_pc + PC_WIDTH'(4);

    // w_ld with zeroed next values means the IF/ID register takes a bubble
    always_comb begin
        w_state_nx = r_state;
        w_pc_nx    = r_pc;
        w_ld       = 1'b0;
        w_valid_nx = 1'b0;
        w_instr_nx = '0;
        w_pc4_nx   = '0;
        w_skid_ld  = 1'b0;
        if (r_state == S_WAIT) begin
            w_state_nx = S_FETCH;
        end else if (branch_taken) begin
            w_pc_nx    = {branch_target[PC_WIDTH-1:2], 2'b00};
            w_ld       = 1'b1;
            w_state_nx = S_FETCH;
        end else if (flush) begin
            w_ld = 1'b1;
            if (r_state == S_HELD) begin
                w_pc_nx    = r_skid_pc4 - PC_WIDTH'(4);
                w_state_nx = S_FETCH;
            end
        end else if (r_state == S_FETCH) begin
            if (w_done) begin
                w_pc_nx = w_pc4;
                if (stall) begin
                    w_skid_ld  = 1'b1;
                    w_state_nx = S_HELD;
                end else begin
                    w_ld       = 1'b1;
                    w_valid_nx = 1'b1;
                    w_instr_nx = imem_rdata;
                    w_pc4_nx   = w_pc4;
                end
            end else begin
                w_ld = !stall;
            end
        end else if (!stall) begin
            w_ld       = 1'b1;
            w_valid_nx = 1'b1;
            w_instr_nx = r_skid_instr;
            w_pc4_nx   = r_skid_pc4;
            w_state_nx = S_FETCH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_WAIT;
            r_pc         <= RESET_PC;
            r_valid      <= 1'b0;
            r_instr      <= '0;
            r_pc4        <= '0;
            r_skid_instr <= '0;
            r_skid_pc4   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_pc    <= w_pc_nx;
            if (w_ld) begin
                r_valid <= w_valid_nx;
                r_instr <= w_instr_nx;
                r_pc4   <= w_pc4_nx;
            end
            if (w_skid_ld) begin
                r_skid_instr <= imem_rdata;
                r_skid_pc4   <= w_pc4;
            end
        end
    end

    assign if_id_valid = r_valid;
    assign if_id_instr = r_instr;
    assign if_id_pc4   = r_pc4;
    assign opcode      = r_instr[31:26];
    assign rs          = r_instr[25:21];
    assign rt          = r_instr[20:16];
    assign rd          = r_instr[15:11];
    assign shamt       = r_instr[10:6];
    assign funct       = r_instr[5:0];
    assign imm16       = r_instr[15:0];
endmodule

// File: tb/tb_if_id_fetch_stage.sv
// tb_if_id_fetch_stage: scoreboard bench; expected IF/ID entries are queued as fetches are driven.
module tb_if_id_fetch_stage;
    logic        clk = 1'b0;
    logic        rst_n, rst2_n;
    logic        imem_req, imem_ready, stall, flush, branch_taken;
    logic [31:0] imem_addr, imem_rdata, branch_target;
    logic        if_id_valid;
    logic [31:0] if_id_instr, if_id_pc4;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm16;
    logic        req2, valid2;
    logic [31:0] addr2, rdata2, instr2, pc4_2;
    logic [5:0]  op2, fn2;
    logic [4:0]  rs2, rt2, rd2, sh2;
    logic [15:0] imm2;
    logic        zero1 = 1'b0;
    logic [31:0] zero32 = '0;
    logic        one1 = 1'b1;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [63:0] sb[$];
    logic [63:0] e;
    logic [31:0] pc_e;
    logic        stall_q = 1'b0;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return 32'h100 + (a >> 2);
    endfunction

    assign imem_rdata = mem(imem_addr);
    assign rdata2     = mem(addr2);

    always #5 clk = ~clk;

    if_id_fetch_stage #(.PC_WIDTH(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .stall(stall), .flush(flush),
        .branch_taken(branch_taken), .branch_target(branch_target), .if_id_valid(if_id_valid),
        .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .opcode(opcode), .rs(rs), .rt(rt),
        .rd(rd), .shamt(shamt), .funct(funct), .imm16(imm16)
    );

    if_id_fetch_stage #(.PC_WIDTH(32), .RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk(clk), .rst_n(rst2_n), .imem_req(req2), .imem_addr(addr2),
        .imem_ready(one1), .imem_rdata(rdata2), .stall(zero1), .flush(zero1),
        .branch_taken(zero1), .branch_target(zero32), .if_id_valid(valid2),
        .if_id_instr(instr2), .if_id_pc4(pc4_2), .opcode(op2), .rs(rs2), .rt(rt2),
        .rd(rd2), .shamt(sh2), .funct(fn2), .imm16(imm2)
    );

    always @(posedge clk) stall_q <= stall;

    // IF/ID takes new content only on an edge where stall was low; a valid entry then must match the queue head
    always @(negedge clk) begin
        if (rst_n && !stall_q && if_id_valid) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got pc4=%h instr=%h required no entry", if_id_pc4, if_id_instr);
            end else begin
                e = sb.pop_front();
                if ({if_id_pc4, if_id_instr} !== e) begin
                    n_fail++;
                    $display("FAIL sb_entry: got pc4=%h instr=%h required pc4=%h instr=%h",
                             if_id_pc4, if_id_instr, e[63:32], e[31:0]);
                end
            end
        end
    end

    task automatic test_reset;
        rst_n = 1'b0; rst2_n = 1'b0; imem_ready = 1'b1;
        stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; branch_target = '0;
        #3;
        n_checks++;
        if ({imem_req, if_id_valid, if_id_instr, if_id_pc4, imem_addr} !== 98'h0) begin
            n_fail++;
            $display("FAIL reset_state: got req=%b v=%b instr=%h pc4=%h addr=%h required all 0",
                     imem_req, if_id_valid, if_id_instr, if_id_pc4, imem_addr);
        end
        n_checks++;
        if ({opcode, rs, rt, rd, shamt, funct, imm16} !== 48'h0) begin
            n_fail++;
            $display("FAIL reset_fields: got op=%h funct=%h imm=%h required 0", opcode, funct, imm16);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_req: got %b required 0", imem_req);
        end
        @(negedge clk);
        pc_e = 32'h0;
    endtask

    task automatic test_sequential;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (imem_req !== 1'b1 || imem_addr !== pc_e) begin
                n_fail++;
                $display("FAIL seq_addr: got req=%b addr=%h required 1 %h", imem_req, imem_addr, pc_e);
            end
            if (i > 0) begin
                n_checks++;
                if (if_id_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL seq_valid: got %b required 1", if_id_valid);
                end
            end
            sb.push_back({pc_e + 32'd4, mem(pc_e)});
            @(negedge clk);
            pc_e += 4;
        end
    endtask

    task automatic test_stall;
        stall = 1'b1;
        sb.push_back({pc_e + 32'd4, mem(pc_e)});
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (imem_req !== 1'b0 || if_id_valid !== 1'b1 || if_id_pc4 !== pc_e || if_id_instr !== mem(pc_e - 32'd4)) begin
                n_fail++;
                $display("FAIL stall_hold: got req=%b v=%b pc4=%h instr=%h required 0 1 %h %h",
                         imem_req, if_id_valid, if_id_pc4, if_id_instr, pc_e, mem(pc_e - 32'd4));
            end
        end
        stall = 1'b0;
        @(negedge clk);
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== pc_e + 32'd4 || if_id_pc4 !== pc_e + 32'd4) begin
            n_fail++;
            $display("FAIL stall_release: got req=%b addr=%h pc4=%h required 1 %h %h",
                     imem_req, imem_addr, if_id_pc4, pc_e + 32'd4, pc_e + 32'd4);
        end
        pc_e += 4;
    endtask

    task automatic test_branch;
        branch_taken = 1'b1;
        branch_target = 32'h0000_0043;
        @(negedge clk);
        branch_taken = 1'b0;
        branch_target = 32'hFFFF_FFFF;
        n_checks++;
        if (if_id_valid !== 1'b0 || opcode !== 6'h0 || if_id_instr !== 32'h0 || imem_addr !== 32'h40 || imem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL branch_redirect: got v=%b op=%h instr=%h addr=%h req=%b required 0 0 0 00000040 1",
                     if_id_valid, opcode, if_id_instr, imem_addr, imem_req);
        end
        pc_e = 32'h40;
        sb.push_back({pc_e + 32'd4, mem(pc_e)});
        @(negedge clk);
        n_checks++;
        if (if_id_valid !== 1'b1 || if_id_pc4 !== 32'h44) begin
            n_fail++;
            $display("FAIL branch_first: got v=%b pc4=%h required 1 00000044", if_id_valid, if_id_pc4);
        end
        pc_e += 4;
    endtask

    task automatic test_flush;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_checks++;
        if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || imem_addr !== pc_e || imem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_bubble: got v=%b instr=%h addr=%h req=%b required 0 0 %h 1",
                     if_id_valid, if_id_instr, imem_addr, imem_req, pc_e);
        end
        sb.push_back({pc_e + 32'd4, mem(pc_e)});
        @(negedge clk);
        n_checks++;
        if (if_id_valid !== 1'b1 || if_id_instr !== mem(pc_e)) begin
            n_fail++;
            $display("FAIL flush_refetch: got v=%b instr=%h required 1 %h", if_id_valid, if_id_instr, mem(pc_e));
        end
        pc_e += 4;
    endtask

    task automatic test_ready_low;
        imem_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++;
            if (imem_req !== 1'b1 || imem_addr !== pc_e || if_id_valid !== 1'b0 ||
                {opcode, rs, rt, rd, shamt, funct, imm16} !== 48'h0) begin
                n_fail++;
                $display("FAIL ready_low: got req=%b addr=%h v=%b op=%h imm=%h required 1 %h 0 0 0",
                         imem_req, imem_addr, if_id_valid, opcode, imm16, pc_e);
            end
        end
        imem_ready = 1'b1;
        sb.push_back({pc_e + 32'd4, mem(pc_e)});
        @(negedge clk);
        n_checks++;
        if (if_id_valid !== 1'b1 || rs !== mem(pc_e)[25:21] || funct !== mem(pc_e)[5:0] || imm16 !== mem(pc_e)[15:0]) begin
            n_fail++;
            $display("FAIL ready_resume: got v=%b rs=%h funct=%h imm=%h required 1 from %h",
                     if_id_valid, rs, funct, imm16, mem(pc_e));
        end
        pc_e += 4;
    endtask

    task automatic test_flush_held;
        stall = 1'b1;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        stall = 1'b0;
        n_checks++;
        if (if_id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== pc_e) begin
            n_fail++;
            $display("FAIL flush_held: got v=%b req=%b addr=%h required 0 1 %h", if_id_valid, imem_req, imem_addr, pc_e);
        end
        sb.push_back({pc_e + 32'd4, mem(pc_e)});
        @(negedge clk);
        pc_e += 4;
    endtask

    task automatic test_async_reset;
        stall = 1'b1;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({imem_req, if_id_valid, if_id_instr, if_id_pc4, imem_addr, opcode, funct} !== 110'h0) begin
            n_fail++;
            $display("FAIL async_reset: got req=%b v=%b instr=%h pc4=%h addr=%h required all 0",
                     imem_req, if_id_valid, if_id_instr, if_id_pc4, imem_addr);
        end
        stall = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_wrap;
        @(negedge clk);
        rst2_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req2 !== 1'b1 || addr2 !== 32'hFFFF_FFF8) begin
            n_fail++;
            $display("FAIL wrap_a0: got req=%b addr=%h required 1 fffffff8", req2, addr2);
        end
        @(negedge clk);
        n_checks++;
        if (addr2 !== 32'hFFFF_FFFC || pc4_2 !== 32'hFFFF_FFFC) begin
            n_fail++;
            $display("FAIL wrap_a1: got addr=%h pc4=%h required fffffffc fffffffc", addr2, pc4_2);
        end
        @(negedge clk);
        n_checks++;
        if (addr2 !== 32'h0 || pc4_2 !== 32'h0 || instr2 !== mem(32'hFFFF_FFFC) || valid2 !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_a2: got addr=%h pc4=%h instr=%h v=%b required 0 0 %h 1",
                     addr2, pc4_2, instr2, valid2, mem(32'hFFFF_FFFC));
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_flush();
        test_ready_low();
        test_flush_held();
        test_async_reset();
        test_wrap();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d entries left required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
